// File: rtl/frv_dmem_pkg.sv
// Shared constants for the dmem responder: FSM encodings, bus widths and defaults.
package frv_dmem_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned StrbW = 4;
    localparam int unsigned CntW  = 4;

    localparam int unsigned DefaultWaitCycles = 1;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StResp = 2'd2;

endpackage

// File: rtl/frv_dmem_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port; no reset.
module frv_dmem_ram
    import frv_dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic               clk,
    input  logic               en,
    input  logic [StrbW-1:0]   we,
    input  logic [IDX_W-1:0]   idx,
    input  logic [DataW-1:0]   wdata,
    output logic [DataW-1:0]   rdata
);

    logic [DataW-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < StrbW; i++) begin
                if (we[i]) begin
                    mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/frv_dmem_responder.sv
// Responder for the core dmem bus: captures a request, stalls for the configured wait states,
// then performs the RAM access and completes with read data or a bus error.
module frv_dmem_responder
    import frv_dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = DefaultWaitCycles
) (
    input  logic               g_clk,
    input  logic               g_reset,
    input  logic               dmem_cen,
    input  logic               dmem_wen,
    input  logic [StrbW-1:0]   dmem_strb,
    input  logic [31:0]        dmem_addr,
    input  logic [DataW-1:0]   dmem_wdata,
    output logic               dmem_stall,
    output logic               dmem_error,
    output logic [DataW-1:0]   dmem_rdata
);

    localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
    localparam logic [32:0] Span = 33'(DEPTH_WORDS) << 2;

    logic [1:0]       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [IdxW-1:0]  idx_q;
    logic             wen_q;
    logic [StrbW-1:0] strb_q;
    logic [DataW-1:0] wdata_q;
    logic             err_q;

    logic             capture;
    logic [31:0]      live_offset;
    logic             live_err;
    logic [IdxW-1:0]  live_idx;

    logic [IdxW-1:0]  sel_idx;
    logic             sel_wen;
    logic [StrbW-1:0] sel_strb;
    logic [DataW-1:0] sel_wdata;
    logic             sel_err;

    logic             ram_en;
    logic [StrbW-1:0] ram_we;
    logic [DataW-1:0] ram_rdata;

    // Offset wraps for addresses below BASE_ADDR, so one unsigned compare covers both bounds.
    assign capture     = (state_q == StIdle) && dmem_cen;
    assign live_offset = dmem_addr - BASE_ADDR;
    assign live_err    = !({1'b0, live_offset} < Span);
    assign live_idx    = live_offset[IdxW+1:2];

    // With zero wait states RESP is entered on the capture edge, so the RAM sees live inputs.
    assign sel_idx   = capture ? live_idx   : idx_q;
    assign sel_wen   = capture ? dmem_wen   : wen_q;
    assign sel_strb  = capture ? dmem_strb  : strb_q;
    assign sel_wdata = capture ? dmem_wdata : wdata_q;
    assign sel_err   = capture ? live_err   : err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (dmem_cen) begin
                    cnt_d   = CntW'(WAIT_CYCLES);
                    state_d = (WAIT_CYCLES > 0) ? StWait : StResp;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d = StResp;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign ram_en = !g_reset && (state_q != StResp) && (state_d == StResp);
    assign ram_we = {StrbW{ram_en && sel_wen && !sel_err}} & sel_strb;

    frv_dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IdxW)
    ) u_ram (
        .clk   (g_clk),
        .en    (ram_en),
        .we    (ram_we),
        .idx   (sel_idx),
        .wdata (sel_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            wen_q   <= 1'b0;
            strb_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (capture) begin
                idx_q   <= live_idx;
                wen_q   <= dmem_wen;
                strb_q  <= dmem_strb;
                wdata_q <= dmem_wdata;
                err_q   <= live_err;
            end
        end
    end

    assign dmem_stall = (state_q == StWait) || ((state_q == StIdle) && dmem_cen);
    assign dmem_error = (state_q == StResp) && err_q;
    assign dmem_rdata = ((state_q == StResp) && !err_q && !wen_q) ? ram_rdata : '0;

endmodule

// File: tb/tb_frv_dmem_responder.sv
// Directed bench: three responders (WAIT_CYCLES 1, 0, 3) driven through a shared request task.
module tb_frv_dmem_responder;

    logic        clk;
    logic        rst   [3];
    logic        cen   [3];
    logic        wen   [3];
    logic [3:0]  strb  [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic        stall [3];
    logic        err   [3];
    logic [31:0] rdata [3];

    int checks = 0;
    int errors = 0;

    frv_dmem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) u_w1 (
        .g_clk(clk), .g_reset(rst[0]), .dmem_cen(cen[0]), .dmem_wen(wen[0]),
        .dmem_strb(strb[0]), .dmem_addr(addr[0]), .dmem_wdata(wdata[0]),
        .dmem_stall(stall[0]), .dmem_error(err[0]), .dmem_rdata(rdata[0])
    );

    frv_dmem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_w0 (
        .g_clk(clk), .g_reset(rst[1]), .dmem_cen(cen[1]), .dmem_wen(wen[1]),
        .dmem_strb(strb[1]), .dmem_addr(addr[1]), .dmem_wdata(wdata[1]),
        .dmem_stall(stall[1]), .dmem_error(err[1]), .dmem_rdata(rdata[1])
    );

    frv_dmem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u_w3 (
        .g_clk(clk), .g_reset(rst[2]), .dmem_cen(cen[2]), .dmem_wen(wen[2]),
        .dmem_strb(strb[2]), .dmem_addr(addr[2]), .dmem_wdata(wdata[2]),
        .dmem_stall(stall[2]), .dmem_error(err[2]), .dmem_rdata(rdata[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the completing cycle.
    task automatic do_req(input int u, input logic w, input logic [3:0] s, input logic [31:0] a,
                          input logic [31:0] d, input bit scramble, output int n,
                          output logic [31:0] rd, output logic e);
        bit done = 0;
        cen[u] = 1'b1; wen[u] = w; strb[u] = s; addr[u] = a; wdata[u] = d;
        n = 0; rd = '0; e = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            #1;
            if (!stall[u]) begin
                rd = rdata[u];
                e = err[u];
                done = 1;
            end else begin
                n++;
                @(negedge clk);
                if (scramble) begin
                    addr[u] = a ^ 32'h4; wdata[u] = ~d; wen[u] = ~w; strb[u] = 4'hF;
                end
            end
        end
        cen[u] = 1'b0;
        if (!done) check("timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic wr(input int u, input string tag, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input int exp_n, input logic exp_e);
        int n; logic [31:0] rd; logic e;
        do_req(u, 1'b1, s, a, d, 1'b0, n, rd, e);
        check({tag, "_stalls"}, 32'(n), 32'(exp_n));
        check({tag, "_err"}, {31'd0, e}, {31'd0, exp_e});
    endtask

    task automatic rd_chk(input int u, input string tag, input logic [31:0] a,
                          input logic [31:0] exp_d, input int exp_n, input logic exp_e,
                          input bit scramble);
        int n; logic [31:0] rd; logic e;
        do_req(u, 1'b0, 4'h0, a, 32'h5A5A_5A5A, scramble, n, rd, e);
        check({tag, "_stalls"}, 32'(n), 32'(exp_n));
        check({tag, "_err"}, {31'd0, e}, {31'd0, exp_e});
        check({tag, "_data"}, rd, exp_d);
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            rst[u] = 1'b1; cen[u] = 1'b0; wen[u] = 1'b0; strb[u] = '0;
            addr[u] = '0; wdata[u] = '0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) rst[u] = 1'b0;
        #1;
        for (int u = 0; u < 3; u++) begin
            check($sformatf("rst_stall%0d", u), {31'd0, stall[u]}, 32'd0);
            check($sformatf("rst_err%0d", u), {31'd0, err[u]}, 32'd0);
            check($sformatf("rst_rdata%0d", u), rdata[u], 32'd0);
        end
        @(negedge clk);

        // WAIT_CYCLES=1: basic write/read, byte strobes, zero strobe, out-of-range
        wr(0, "w1_wr10", 32'h10, 32'hDEAD_BEEF, 4'hF, 2, 1'b0);
        rd_chk(0, "w1_rd10", 32'h10, 32'hDEAD_BEEF, 2, 1'b0, 1'b0);
        wr(0, "w1_wr14", 32'h14, 32'h1122_3344, 4'hF, 2, 1'b0);
        wr(0, "w1_strb", 32'h14, 32'hAABB_CCDD, 4'b0101, 2, 1'b0);
        rd_chk(0, "w1_rd14", 32'h14, 32'h11BB_33DD, 2, 1'b0, 1'b0);
        wr(0, "w1_strb0", 32'h14, 32'hFFFF_FFFF, 4'b0000, 2, 1'b0);
        rd_chk(0, "w1_rd14b", 32'h14, 32'h11BB_33DD, 2, 1'b0, 1'b0);
        wr(0, "w1_wr0", 32'h0, 32'h0BAD_F00D, 4'hF, 2, 1'b0);
        rd_chk(0, "w1_rd_oor", 32'h100, 32'h0, 2, 1'b1, 1'b0);
        wr(0, "w1_wr_oor", 32'h100, 32'hFFFF_FFFF, 4'hF, 2, 1'b1);
        rd_chk(0, "w1_rd0", 32'h0, 32'h0BAD_F00D, 2, 1'b0, 1'b0);
        rd_chk(0, "w1_rd_low2", 32'h13, 32'hDEAD_BEEF, 2, 1'b0, 1'b0);

        // WAIT_CYCLES=0: back-to-back, one stall each
        wr(1, "w0_wr0", 32'h0, 32'h1111_1111, 4'hF, 1, 1'b0);
        wr(1, "w0_wr4", 32'h4, 32'h2222_2222, 4'hF, 1, 1'b0);
        wr(1, "w0_wr8", 32'h8, 32'h3333_3333, 4'hF, 1, 1'b0);
        rd_chk(1, "w0_rd0", 32'h0, 32'h1111_1111, 1, 1'b0, 1'b0);
        rd_chk(1, "w0_rd4", 32'h4, 32'h2222_2222, 1, 1'b0, 1'b0);
        rd_chk(1, "w0_rd8", 32'h8, 32'h3333_3333, 1, 1'b0, 1'b0);
        wr(1, "w0_strb", 32'h4, 32'hAABB_CCDD, 4'b1010, 1, 1'b0);
        rd_chk(1, "w0_rd4b", 32'h4, 32'hAA22_CC22, 1, 1'b0, 1'b0);

        // WAIT_CYCLES=3: flush keeps the write
        cen[2] = 1'b1; wen[2] = 1'b1; strb[2] = 4'hF; addr[2] = 32'h20; wdata[2] = 32'hCAFE_F00D;
        #1;
        check("w3_flush_stall", {31'd0, stall[2]}, 32'd1);
        @(negedge clk);
        cen[2] = 1'b0;
        repeat (6) @(negedge clk);
        rd_chk(2, "w3_rd20", 32'h20, 32'hCAFE_F00D, 4, 1'b0, 1'b1);

        // WAIT_CYCLES=3: reset one edge before RESP entry aborts the write
        wr(2, "w3_wr30", 32'h30, 32'h0, 4'hF, 4, 1'b0);
        cen[2] = 1'b1; wen[2] = 1'b1; strb[2] = 4'hF; addr[2] = 32'h30; wdata[2] = 32'h1234_5678;
        repeat (3) @(negedge clk);
        #1;
        check("w3_busy", {31'd0, stall[2]}, 32'd1);
        rst[2] = 1'b1;
        cen[2] = 1'b0;
        @(negedge clk);
        #1;
        check("w3_rst_stall", {31'd0, stall[2]}, 32'd0);
        check("w3_rst_err", {31'd0, err[2]}, 32'd0);
        check("w3_rst_rdata", rdata[2], 32'd0);
        rst[2] = 1'b0;
        @(negedge clk);
        rd_chk(2, "w3_rd30", 32'h30, 32'h0, 4, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/frv_dmem_responder.md
Name: frv_dmem_responder

Overview:
- Responder end of the core data-memory interface (dmem_*).
- Accepts read and write requests from the pipeline backend and backs them with a byte-writable on-chip word RAM.
- Drives dmem_stall for a configurable number of wait states, then returns read data or an error.
- Used as the tightly-coupled data memory in core-level simulation and FPGA builds.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM (power of two).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be aligned to 4*DEPTH_WORDS.
- WAIT_CYCLES, 1, extra stall cycles per request (0..15).

Ports:
- g_clk  input  1  global clock
- g_reset  input  1  synchronous reset, active high
- dmem_cen  input  1  request valid
- dmem_wen  input  1  1 = write, 0 = read
- dmem_strb  input  4  byte write strobes; ignored on reads
- dmem_addr  input  32  byte address; bits [1:0] ignored (word access)
- dmem_wdata  input  32  write data
- dmem_stall  output  1  request not yet complete; requester holds all inputs
- dmem_error  output  1  bus error; valid only in the completing cycle
- dmem_rdata  output  32  read data; valid only in the completing cycle

Behaviour:
- Protocol:
  - A request completes in the cycle where dmem_cen=1 and dmem_stall=0.
  - dmem_rdata and dmem_error are meaningful only in that cycle. Outside it they are 0.
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- IDLE:
  - dmem_stall = dmem_cen (combinational).
  - If dmem_cen=1: capture addr, wen, strb, wdata into request registers; load wait counter with WAIT_CYCLES.
  - Go to WAIT if WAIT_CYCLES>0, otherwise go to RESP.
- WAIT:
  - dmem_stall=1; counter decrements by 1 each cycle.
  - When counter==1, go to RESP.
- Entry into RESP (clock edge):
  - RAM access is performed with the captured request.
  - Write: bytes with strb[i]=1 are updated; other bytes are unchanged.
  - Read: word is registered into the response register.
- RESP:
  - dmem_stall=0; dmem_rdata = response register; dmem_error = captured error flag.
  - Always returns to IDLE next cycle. A back-to-back request is seen in IDLE and costs at least 1 stall cycle.
- Latency: WAIT_CYCLES+1 stall cycles per request, then a 1-cycle completion.
- Error:
  - Condition: captured address outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS).
  - RAM is not written; dmem_rdata=0; dmem_error=1 in RESP.
  - Range check is computed at capture and registered.
- Index: RAM word index = (addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits.
- Write with strb=4'b0000: completes normally, no RAM change, no error.
- dmem_cen dropped during WAIT (flush): the captured request still completes, including the write. The FSM passes through RESP; outputs there are don't-care to the requester.
- Input changes while dmem_stall=1 are ignored; only captured values are used.
- Reset:
  - Values on reset: dmem_stall=0 (dmem_cen low), dmem_error=0, dmem_rdata=0, state=IDLE, counter=0.
  - Reset mid-request aborts it; a pending write is not committed.
  - RAM contents are not reset.
- Read-after-write to the same word on consecutive requests returns the new data; there is no forwarding hazard, because the write commits before the next capture.

Decomposition:
- Shared package/header:
  - FSM state encodings (2-bit IDLE/WAIT/RESP).
  - Width constants (32-bit data, 4-bit strobe).
  - Default WAIT_CYCLES.
- Sub-module frv_dmem_ram:
  - Synchronous single-port RAM, DEPTH_WORDS x 32.
  - Per-byte write enables.
  - Registered read, 1-cycle latency.
  - No reset.
- The top level holds the FSM, wait counter, request and response registers, and the range check.

Test Plan:
- Write/read: WAIT_CYCLES=1. Write addr 0x10, wdata 0xDEADBEEF, strb 4'hF → stall high 2 cycles, completes with error=0. Then read 0x10 → 2 stall cycles, rdata=0xDEADBEEF.
- Byte strobes: word holds 0x11223344. Write wdata 0xAABBCCDD, strb 4'b0101 → read returns 0x11BB33DD.
- Error: read addr BASE_ADDR+4*DEPTH_WORDS → dmem_error=1, rdata=0 in the completing cycle. Write to the same addr → error=1, and a read of word 0 is unchanged.
- Zero wait: WAIT_CYCLES=0. Back-to-back reads of 0x0, 0x4, 0x8 → each shows exactly 1 stall cycle, then completes with correct data. The IDLE/RESP alternation is visible.
- Flush: WAIT_CYCLES=3. Write 0x20=0xCAFEF00D, drop cen after 1 stall cycle → a later read of 0x20 returns 0xCAFEF00D.
- Reset mid-op: WAIT_CYCLES=3. Start write 0x30=0x12345678 over prior 0x0; assert g_reset in WAIT → stall=0, error=0 next cycle. A read of 0x30 returns 0x0.
